// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-entry front end.
// - state_t     : edit FSM states (IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT)
// - HOUR_MAX    : largest legal hour value
// - MIN_SEC_MAX : largest legal minute/second value
// - FIELD_*     : codes driven on the field output
// - wrap_step() : +1/-1 with wrap-around inside 0..max
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [7:0] HOUR_MAX    = 8'd23;
  localparam logic [7:0] MIN_SEC_MAX = 8'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // One step up or down with wrap. An out-of-range value is pulled back
  // into range, so the edited value can never escape 0..max.
  function automatic logic [7:0] wrap_step(input logic [7:0] v,
                                           input logic [7:0] max,
                                           input logic       up);
    if (up) return (v >= max) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0 || v > max) ? max : v - 8'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_key_debounce.sv
// key_debounce: push-button conditioner.
// Raw key -> 2-FF synchroniser -> stability counter -> filtered level ->
// registered rising-edge pulse. The filtered level flips only after
// DEB_CYCLES consecutive synchronised samples disagree with it.
// Ports:
// - clk, rst : system clock, synchronous active-high reset (clears to released)
// - key      : raw asynchronous key, active-high
// - press    : one-cycle pulse, DEB_CYCLES+3 cycles after a clean press
module key_debounce #(
  parameter int DEB_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      // Any sample that agrees with the current level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: user-entry front end for the clock/alarm.
// Debounces five keys, lets the user edit an HH:MM:SS snapshot of the live
// time field by field, and emits a one-cycle load strobe on commit.
// Ports:
// - clk, rst                     : clock, synchronous active-high reset
// - key_edit/inc/dec/ok/esc      : raw active-high keys
// - cur_hour/min/sec             : live time, snapshotted on edit entry
// - set_hour/min/sec             : edited value (valid with load)
// - editing                      : high in EDIT_H/EDIT_M/EDIT_S
// - field                        : 0 none, 1 hour, 2 min, 3 sec
// - blink                        : toggles every BLINK_DIV cycles while editing
// - load                         : one-cycle strobe in COMMIT
// - fsm_state                    : current FSM state, for observation
// Handshake: load is a fire-and-forget strobe; set_* is valid in the same
// cycle and the reader has no back-pressure.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_edit,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_ok,
  input  logic       key_esc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic       editing,
  output logic [1:0] field,
  output logic       blink,
  output logic       load,
  output state_t     fsm_state
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic p_edit, p_inc, p_dec, p_ok, p_esc;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_edit (.clk(clk), .rst(rst), .key(key_edit), .press(p_edit));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc  (.clk(clk), .rst(rst), .key(key_inc),  .press(p_inc));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec  (.clk(clk), .rst(rst), .key(key_dec),  .press(p_dec));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok   (.clk(clk), .rst(rst), .key(key_ok),   .press(p_ok));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_esc  (.clk(clk), .rst(rst), .key(key_esc),  .press(p_esc));

  state_t     state, state_n;
  logic [7:0] hour_n, min_n, sec_n;
  logic       step_en, step_up;

  // inc and dec together cancel out.
  assign step_en = p_inc ^ p_dec;
  assign step_up = p_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      set_hour <= 8'd0;
      set_min  <= 8'd0;
      set_sec  <= 8'd0;
    end else begin
      state    <= state_n;
      set_hour <= hour_n;
      set_min  <= min_n;
      set_sec  <= sec_n;
    end
  end

  // Priority inside the edit states: esc > ok > edit > inc/dec.
  always_comb begin
    state_n = state;
    hour_n  = set_hour;
    min_n   = set_min;
    sec_n   = set_sec;
    case (state)
      IDLE: begin
        if (p_edit) begin
          state_n = EDIT_H;
          hour_n  = cur_hour;
          min_n   = cur_min;
          sec_n   = cur_sec;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (p_esc) begin
          state_n = IDLE;
        end else if (p_ok) begin
          state_n = COMMIT;
        end else if (p_edit) begin
          state_n = (state == EDIT_H) ? EDIT_M :
                    (state == EDIT_M) ? EDIT_S : EDIT_H;
        end else if (step_en) begin
          if (state == EDIT_H)      hour_n = wrap_step(set_hour, HOUR_MAX, step_up);
          else if (state == EDIT_M) min_n  = wrap_step(set_min, MIN_SEC_MAX, step_up);
          else                      sec_n  = wrap_step(set_sec, MIN_SEC_MAX, step_up);
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    editing = 1'b0;
    field   = FIELD_NONE;
    load    = 1'b0;
    case (state)
      EDIT_H: begin editing = 1'b1; field = FIELD_HOUR; end
      EDIT_M: begin editing = 1'b1; field = FIELD_MIN;  end
      EDIT_S: begin editing = 1'b1; field = FIELD_SEC;  end
      COMMIT: load = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state = state;

  // Blink divider runs only while editing and restarts on every entry.
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  always_ff @(posedge clk) begin
    if (rst || !editing) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Masked so blink drops in the same cycle editing does.
  assign blink = blink_q & editing;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with DEB_CYCLES = 4 and BLINK_DIV = 8.
// A behavioural model (sample-window debounce, integer modulo arithmetic,
// edit-time counter for blink) predicts every output each cycle; directed
// scenarios add literal expectations.
module tb_time_set_ctrl;
  import time_set_ctrl_pkg::*;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int NK    = 5;
  localparam int K_EDIT = 0, K_INC = 1, K_DEC = 2, K_OK = 3, K_ESC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NK-1:0] keys = '0;
  logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
  logic [7:0] set_hour, set_min, set_sec;
  logic       editing, blink, load;
  logic [1:0] field;
  state_t     fsm_state;

  time_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .rst(rst),
    .key_edit(keys[K_EDIT]), .key_inc(keys[K_INC]), .key_dec(keys[K_DEC]),
    .key_ok(keys[K_OK]), .key_esc(keys[K_ESC]),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .editing(editing), .field(field), .blink(blink), .load(load),
    .fsm_state(fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the newest raw sample; the synchroniser delay means the
  // window used at an edge is hist[1..DEB].
  bit [NK-1:0] hist [0:DEB];
  bit [NK-1:0] m_lvl, m_lvl_prev, m_pulse, lvl_next;
  int          m_mode;          // 0 idle, 1 hour, 2 min, 3 sec, 4 commit
  int          m_h, m_m, m_s, n_edit, d;
  bit          m_ready = 1'b0, was_edit, all_diff;

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= DEB; j++) hist[j] = '0;
      m_lvl = '0; m_lvl_prev = '0; m_pulse = '0;
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; n_edit = 0;
      m_ready = 1'b1;
    end else begin
      was_edit = (m_mode >= 1 && m_mode <= 3);
      if (m_mode == 0) begin
        if (m_pulse[K_EDIT]) begin
          m_mode = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
        end
      end else if (m_mode == 4) begin
        m_mode = 0;
      end else if (m_pulse[K_ESC]) begin
        m_mode = 0;
      end else if (m_pulse[K_OK]) begin
        m_mode = 4;
      end else if (m_pulse[K_EDIT]) begin
        m_mode = m_mode % 3 + 1;
      end else if (m_pulse[K_INC] != m_pulse[K_DEC]) begin
        d = m_pulse[K_INC] ? 1 : -1;
        case (m_mode)
          1: m_h = (m_h + d + 24) % 24;
          2: m_m = (m_m + d + 60) % 60;
          default: m_s = (m_s + d + 60) % 60;
        endcase
      end
      n_edit = was_edit ? n_edit + 1 : 0;
      for (int k = 0; k < NK; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[j][k] == m_lvl[k]) all_diff = 1'b0;
        lvl_next[k] = all_diff ? ~m_lvl[k] : m_lvl[k];
      end
      m_pulse    = m_lvl & ~m_lvl_prev;
      m_lvl_prev = m_lvl;
      m_lvl      = lvl_next;
      for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = keys;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      chk("set_hour", set_hour, m_h);
      chk("set_min",  set_min,  m_m);
      chk("set_sec",  set_sec,  m_s);
      chk("editing",  editing,  (m_mode >= 1 && m_mode <= 3));
      chk("field",    field,    (m_mode >= 1 && m_mode <= 3) ? m_mode : 0);
      chk("load",     load,     m_mode == 4);
      chk("blink",    blink,    (m_mode >= 1 && m_mode <= 3) && ((n_edit / BLINK) % 2 == 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NK-1:0] m);
    keys = m;
    cycles(10);
    keys = '0;
    cycles(12);
  endtask

  task automatic chk_set(input string name, input int h, input int mi, input int s);
    chk({name, "_hour"}, set_hour, h);
    chk({name, "_min"},  set_min,  mi);
    chk({name, "_sec"},  set_sec,  s);
  endtask

  // ---------------- directed scenarios ----------------
  int  t1, t2;
  bit  prev_b, found;

  initial begin
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk_set("reset", 0, 0, 0);
    chk("reset_editing", editing, 0);
    chk("reset_field", field, 0);
    chk("reset_load", load, 0);
    chk("reset_blink", blink, 0);

    // Entry snapshot and hour wrap.
    cur_hour = 8'd23; cur_min = 8'd59; cur_sec = 8'd58;
    press(5'b1 << K_EDIT);
    chk_set("entry", 23, 59, 58);
    chk("entry_field", field, 1);
    cur_hour = 8'd5; cur_min = 8'd7;   // ignored while editing
    press(5'b1 << K_INC);
    chk_set("hour_wrap", 0, 59, 58);
    chk("hour_wrap_field", field, 1);

    // Minute wrap.
    press(5'b1 << K_EDIT);
    press(5'b1 << K_INC);
    chk_set("min_wrap", 0, 0, 58);
    chk("min_field", field, 2);

    // Seconds decrement x3.
    press(5'b1 << K_EDIT);
    repeat (3) press(5'b1 << K_DEC);
    chk_set("sec_dec", 0, 0, 55);
    chk("sec_field", field, 3);

    // Blink period while editing.
    t1 = -1; t2 = -1; prev_b = blink;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (blink && !prev_b) begin
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
      prev_b = blink;
    end
    chk("blink_period", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, 16);

    // Abort keeps the last value.
    press(5'b1 << K_ESC);
    chk("esc_editing", editing, 0);
    chk_set("esc_hold", 0, 0, 55);
    cycles(20);
    chk("idle_blink", blink, 0);

    // Commit 12:34:56 from EDIT_S.
    cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
    press(5'b1 << K_EDIT);
    press(5'b1 << K_EDIT);
    press(5'b1 << K_EDIT);
    chk("pre_commit_field", field, 3);
    keys = 5'b1 << K_OK;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (load) found = 1'b1;
    end
    chk("load_seen", found, 1);
    chk_set("commit", 12, 34, 56);
    cycles(1);
    chk("load_one_cycle", load, 0);
    chk("post_commit_editing", editing, 0);
    chk("post_commit_field", field, 0);
    keys = '0;
    cycles(12);

    // Bounce: 1,0,1 then held -> one increment.
    press(5'b1 << K_EDIT);
    keys = 5'b1 << K_INC; cycles(1);
    keys = '0;            cycles(1);
    keys = 5'b1 << K_INC; cycles(11);
    keys = '0;            cycles(12);
    chk("bounce_hour", set_hour, 13);

    // inc + dec together -> no change.
    press((5'b1 << K_INC) | (5'b1 << K_DEC));
    chk("incdec_hour", set_hour, 13);

    // esc + ok together -> idle, no load (load is also checked every cycle).
    press((5'b1 << K_ESC) | (5'b1 << K_OK));
    chk("escok_editing", editing, 0);
    chk_set("escok_hold", 13, 34, 56);

    // Reset arrives in the cycle p_ok is high, while in EDIT_M.
    press(5'b1 << K_EDIT);
    press(5'b1 << K_EDIT);
    chk("midedit_field", field, 2);
    keys = 5'b1 << K_OK;
    cycles(7);
    chk("midedit_still_edit", editing, 1);
    rst  = 1'b1;
    keys = '0;
    cycles(1);
    chk("rst_no_load", load, 0);
    cycles(2);
    rst = 1'b0;
    chk_set("rst_mid", 0, 0, 0);
    chk("rst_mid_editing", editing, 0);
    chk("rst_mid_field", field, 0);
    chk("rst_mid_blink", blink, 0);

    // inc/dec/ok/esc ignored in IDLE.
    press(5'b1 << K_INC);
    press(5'b1 << K_OK);
    press(5'b1 << K_ESC);
    chk("idle_ignore_editing", editing, 0);
    chk_set("idle_ignore", 0, 0, 0);

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
